ex_result_stage: RTL
====================

# ex_result_stage

Execute-to-writeback pipeline stage for the RISC datapath. It sits directly downstream of the ALU, including the `diff` first-difference unit. It registers the ALU result, destination register and flags behind a valid/ready handshake with a 2-entry skid buffer, so writeback stalls never create a combinational ready path back into the ALU. It also holds the architectural `eq`/`carry` flag register that branch logic reads.

## Interface
- `DW`, 32, datapath/result width
- `RW`, 5, register-index width

- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  synchronous; drops all buffered entries
- `in_valid`  in  1  ALU result valid
- `in_ready`  out  1  stage can accept; registered, i.e. driven only from flops
- `in_result`  in  DW  ALU result; the `diff` op supplies `{26'b0, diff[5:0]}`
- `in_rd`  in  RW  destination register index
- `in_we`  in  1  register-write enable for this result
- `in_setflags`  in  1  result updates the flag register
- `in_eq`, `in_cout`  in  1 each  flags produced with the result
- `out_valid`  out  1  writeback entry valid
- `out_ready`  in  1  writeback accepts
- `out_result`  out  DW  buffered result
- `out_rd`  out  RW  buffered destination
- `out_we`  out  1  buffered write enable; forced 0 whenever `out_valid` is 0
- `eq_flag`, `carry_flag`  out  1 each  architectural flags
- `occupancy`  out  2  buffered entry count, 0..2

## Operation
- Storage is two slots: main, which drives the `out_*` ports, and skid.
- Transfer rules:
  - Accept = `in_valid & in_ready`.
  - Pop = `out_valid & out_ready`.
- `in_ready` = skid slot empty.
- Fill and drain order:
  - On accept, data loads main if main is empty or popping in the same cycle. Otherwise it loads skid.
  - On pop with skid full, skid moves to main and skid empties.
  - Ordering is strict FIFO; no entry is ever lost or duplicated.
- Simultaneous accept and pop:
  - With occupancy 1, occupancy stays 1 and main takes the new entry.
  - With occupancy 2, accept is impossible because `in_ready` = 0.
- Flags:
  - On accept with `in_setflags` = 1, load `eq_flag <= in_eq` and `carry_flag <= in_cout` at that edge.
  - Flags otherwise hold.
  - Flags are updated at acceptance, not at pop, so branch logic sees them one cycle after the ALU hands off.
- `flush`:
  - Clears both slot valids next edge; occupancy becomes 0.
  - Any accept in the same cycle is discarded. Its flag update is also suppressed.
  - Flags already set by earlier accepts are retained.
  - Data registers need not be cleared.
- Reset: all valids 0, `occupancy` = 0, `in_ready` = 1, `eq_flag` = 0, `carry_flag` = 0, `out_result` = 0, `out_rd` = 0, `out_we` = 0.

## Timing
- Latency is 1 cycle: a result accepted at edge N is on `out_*` with `out_valid` = 1 after edge N.
- Throughput is 1 entry/cycle while `out_ready` = 1.
- Backpressure:
  - `in_ready` falls the edge after the second entry is captured.
  - It rises the edge after a pop empties skid.
- Reset may assert mid-transfer. All entries are then dropped asynchronously and outputs take their reset values immediately, with no clock needed.
- Flush has priority over accept and pop. Reset has priority over everything.

## Structure
- Shared package `risc_pkg` holds:
  - `DW` and `RW` defaults.
  - A packed struct type `ex_result_t` {result, rd, we, setflags, eq, cout}.
  - The constant `DIFF_W` = 6, so the zero-extension width of the `diff` result lives in one place.
- One natural sub-module, `skid_slot2`: a generic 2-entry valid/ready buffer parameterised on payload width. `ex_result_stage` wraps it and adds the flag register and `flush` handling.

## Test plan
- Reset mid-stream: fill 2 entries, assert `rst` between edges → `out_valid` = 0, `in_ready` = 1, `occupancy` = 0 and both flags 0 immediately, without a clock edge.
- Streaming: 4 back-to-back accepts with `out_ready` = 1, results `0x1`, `0x2`, `0x3`, `0x4` → each appears on `out_result` 1 cycle after acceptance, in order, `occupancy` stays 1.
- Backpressure: `out_ready` = 0, send `0xA`, `0xB`, `0xC` → `0xA`, `0xB` accepted, `in_ready` = 0 and `0xC` held. Raise `out_ready` → pops `0xA`, `0xB`, `0xC` in order with no loss or duplicate.
- Diff flags: accept `in_result` = `0x8`, `in_eq` = 0, `in_cout` = 1, `in_setflags` = 1 → `eq_flag` = 0, `carry_flag` = 1 after that edge. Next accept with `in_setflags` = 0 and `in_eq` = 1 → flags unchanged.
- Flush with accept: occupancy 2, assert `flush` with `in_valid` = 1 and `in_setflags` = 1, `in_eq` = 1 → occupancy 0, `out_valid` = 0, `eq_flag` unchanged.
- Write-enable gating: after the buffer empties, `out_we` = 0 regardless of the stored `we` value.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared types and widths for the RISC execute/writeback path.
// Holds datapath defaults, the EX result bundle and diff-result helpers.
package risc_pkg;

    localparam int DW     = 32;
    localparam int RW     = 5;
    localparam int DIFF_W = 6;

    typedef struct packed {
        logic [DW-1:0] result;
        logic [RW-1:0] rd;
        logic          we;
        logic          setflags;
        logic          eq;
        logic          cout;
    } ex_result_t;

    // The diff unit produces a DIFF_W-bit index, zero-extended onto the datapath.
    function automatic logic [DW-1:0] diff_ext(input logic [DIFF_W-1:0] d);
        return {{(DW - DIFF_W){1'b0}}, d};
    endfunction

endpackage

// File: rtl/skid_slot2.sv
// Generic 2-entry valid/ready buffer with main and skid slots.
// in_ready depends only on flops, breaking the upstream ready path.
module skid_slot2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    logic         r_main_v;
    logic         r_skid_v;
    logic [W-1:0] r_main_d;
    logic [W-1:0] r_skid_d;
    logic         w_acc;
    logic         w_pop;

    assign in_ready  = ~r_skid_v;
    assign out_valid = r_main_v;
    assign out_data  = r_main_d;
    assign occupancy = {r_main_v & r_skid_v, r_main_v ^ r_skid_v};

    assign w_acc = in_valid & ~r_skid_v & ~i_clr;
    assign w_pop = r_main_v & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main_d <= '0;
            r_skid_d <= '0;
        end else if (i_clr) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (w_acc && (!r_main_v || w_pop)) begin
            // Skid is necessarily empty here, so main is the FIFO head.
            r_main_v <= 1'b1;
            r_main_d <= in_data;
        end else if (w_acc) begin
            r_skid_v <= 1'b1;
            r_skid_d <= in_data;
        end else if (w_pop) begin
            r_main_v <= r_skid_v;
            r_main_d <= r_skid_v ? r_skid_d : r_main_d;
            r_skid_v <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_result_stage.sv
// Execute-to-writeback stage: skid-buffered ALU result plus the
// architectural eq/carry flag register, with synchronous flush.
module ex_result_stage
    import risc_pkg::*;
#(
    parameter int DW = risc_pkg::DW,
    parameter int RW = risc_pkg::RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_result,
    input  logic [RW-1:0] in_rd,
    input  logic          in_we,
    input  logic          in_setflags,
    input  logic          in_eq,
    input  logic          in_cout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic [RW-1:0] out_rd,
    output logic          out_we,
    output logic          eq_flag,
    output logic          carry_flag,
    output logic [1:0]    occupancy
);

    localparam int PW = DW + RW + 1;

    logic [PW-1:0] w_in_data;
    logic [PW-1:0] w_out_data;
    logic          w_acc;
    logic          r_eq;
    logic          r_carry;

    assign w_in_data = {in_result, in_rd, in_we};
    assign w_acc     = in_valid & in_ready & ~flush;

    skid_slot2 #(
        .W(PW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_data),
        .occupancy (occupancy)
    );

    assign out_result = w_out_data[PW-1 -: DW];
    assign out_rd     = w_out_data[RW:1];
    assign out_we     = w_out_data[0] & out_valid;

    // Flags commit at acceptance so branches see them one cycle after handoff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_eq    <= 1'b0;
            r_carry <= 1'b0;
        end else if (w_acc && in_setflags) begin
            r_eq    <= in_eq;
            r_carry <= in_cout;
        end
    end

    assign eq_flag    = r_eq;
    assign carry_flag = r_carry;

endmodule
